fpu_fma_param: RTL and testbench
================================

# fpu_fma_param

- Parametrised multi-cycle fused multiply-add unit: computes `a*b + c` on IEEE-754-style operands of configurable exponent/mantissa width.
- Successor to the single-precision multiply FMA. Adds:
  - a true addend operand;
  - an accumulate mode that feeds back the previous result;
  - invalid-operand detection.
- Sits behind the FPU operand request interface and drives the answer/flag bus read by the register file.

## Interface

Parameters:
- `EXPBITS`, 8, exponent width (≥3).
- `MANBITS`, 23, stored mantissa width (≥2).
- `FP`, `1+EXPBITS+MANBITS`, operand width. Derived; do not override.

Ports (one clock; reset is asynchronous, active-low):
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous active-low reset.
- `req_in`  in  1  operand request. Accepted when `busy_out`=0.
- `acc_sel_in`  in  1  1: use the internal accumulator as addend instead of `c_in`.
- `a_in`, `b_in`, `c_in`  in  FP each  operands `{sign, exponent, mantissa}`.
- `busy_out`  out  1  high in every state except IDLE.
- `answer_out`  out  FP  result. Held until the next OUTPUT.
- `ready_answer_out`  out  1  one-cycle pulse in OUTPUT.
- `overflow_out`, `underflow_out`, `invalid_out`  out  1 each  flags. Valid with `ready_answer_out`; held with `answer_out`.
- `state_out`  out  3  current `fma_state_e`.

## Operation

- Bias = 2^(EXPBITS-1)-1.
- Operand classes:
  - Exponent 0 is zero; the mantissa is ignored (denormals flushed).
  - Exponent all-ones is invalid.
- FSM: IDLE→LOAD→MULTIPLY→ALIGN→ACCUMULATE→NORMALIZE→OUTPUT→IDLE.
  - Error path: LOAD→ERROR→OUTPUT.
- IDLE: on `req_in`, capture `a_in`, `b_in`, and the addend (`c_in`, or the accumulator if `acc_sel_in`=1), then go to LOAD.
  - `req_in` while busy is ignored; no queueing.
- LOAD: classify operands. Any invalid operand → ERROR.
- MULTIPLY:
  - Product significand = `{1,ma}*{1,mb}`, width 2*(MANBITS+1).
  - Product exponent = ea+eb-bias, in a signed (EXPBITS+2)-bit word.
  - Sign = sa^sb.
  - If either factor is zero, the product is zero.
- ALIGN: right-shift the smaller-exponent significand by the exponent difference.
  - The addend significand is first placed at product scale.
  - Shift saturates at 2*MANBITS+4 (result 0).
  - No sticky bit.
- ACCUMULATE:
  - Equal signs: add magnitudes.
  - Otherwise: subtract the smaller from the larger; sign follows the larger.
- NORMALIZE: leading-one detect, shift, and adjust the exponent. Rounding is truncate (toward zero).
  - Exact zero → +0, no flags.
  - Exponent ≥ 2^EXPBITS-1 → ±infinity (exponent all-ones, mantissa 0), `overflow_out`=1.
  - Exponent ≤ 0 → ±0, `underflow_out`=1.
- ERROR: result is canonical NaN `{0, all-ones, 1<<(MANBITS-1)}`, `invalid_out`=1. Other flags 0.
- OUTPUT:
  - Register the result and flags.
  - Pulse `ready_answer_out`.
  - Load the accumulator with `answer_out` (including NaN/infinity).
  - Return to IDLE.

## Timing

- Reset values:
  - state IDLE;
  - `answer_out`=0, accumulator=0;
  - all flags 0, `ready_answer_out`=0, `busy_out`=0.
- Reset asserted mid-operation aborts immediately; no OUTPUT pulse follows.
- Accept edge = T0 (the edge where `req_in` is high in IDLE). `busy_out`=1 from T0+1.
- Valid path:
  - `ready_answer_out` high in cycle T0+6 only.
  - IDLE at T0+7; a new request can be accepted at the T0+7 edge.
- Invalid path: OUTPUT at T0+3, IDLE at T0+4.
- Operands are sampled only at T0; later input changes have no effect.
- With `acc_sel_in`=1 on back-to-back requests, the addend is the answer of the immediately preceding OUTPUT.

## Structure

- Shared package `fpu_pkg` holds:
  - `fma_state_e` (IDLE, LOAD, MULTIPLY, ALIGN, ACCUMULATE, NORMALIZE, OUTPUT, ERROR);
  - the bool enum;
  - helper functions `fp_bias(EXPBITS)` and `fp_is_special`.
- Operand and float structs are declared locally, since they depend on the module's parameters.
- One sub-module: `fpu_lzc`, a parametrised leading-zero counter (WIDTH parameter; count output; all-zero flag). Used in NORMALIZE.

## Test plan

- 0x3F800000*0x3F800000+0x00000000:
  - `ready_answer_out` exactly at T0+6 with answer 0x3F800000, no flags;
  - `busy_out` high T0+1..T0+6.
- 0x40000000*0x40400000+0x3F800000 → 0x40E00000 (7.0). Then with `acc_sel_in`=1: 0x3FC00000*0x40000000 + acc → 0x41200000 (10.0).
- 0x7F000000*0x7F000000+0 → 0x7F800000, `overflow_out`=1. 0x00800000*0x00800000+0 → 0x00000000, `underflow_out`=1.
- 0x3F800000*0x3F800000+0xBF800000 → 0x00000000, no flags. `req_in` held high during busy → exactly one answer.
- `a_in`=0x7FC00000 → ERROR visible on `state_out`, answer 0x7FC00000, `invalid_out`=1, `ready_answer_out` at T0+3.
- Reset asserted in ALIGN: outputs return to reset values asynchronously; no pulse. After release, a fresh request completes normally.
- EXPBITS=5, MANBITS=10 build: 0x3C00*0x4000+0x3C00 → 0x4200 (3.0).

Source files
------------

// File: rtl/fpu_pkg.sv
// ============================================================================
// Module      : fpu_pkg
// Description : Shared FMA state encoding, boolean type and float helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpu_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD       = 3'd1,
        MULTIPLY   = 3'd2,
        ALIGN      = 3'd3,
        ACCUMULATE = 3'd4,
        NORMALIZE  = 3'd5,
        OUTPUT     = 3'd6,
        ERROR      = 3'd7
    } fma_state_e;

    typedef enum logic {
        FALSE = 1'b0,
        TRUE  = 1'b1
    } bool_e;

    function automatic int fp_bias(input int expbits);
        return (1 << (expbits - 1)) - 1;
    endfunction

    // An all-ones exponent marks an operand this unit refuses to compute with.
    function automatic bool_e fp_is_special(input logic [31:0] exp_field, input int expbits);
        return (exp_field == ((32'd1 << expbits) - 32'd1)) ? TRUE : FALSE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_fma_param_if.sv
// ============================================================================
// Module      : fpu_fma_param_if
// Description : Operand request / answer bus between issuer and FMA unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fpu_fma_param_if #(
    parameter int EXPBITS = 8,
    parameter int MANBITS = 23,
    parameter int FP      = 1 + EXPBITS + MANBITS
);
    logic          req_in;
    logic          acc_sel_in;
    logic [FP-1:0] a_in;
    logic [FP-1:0] b_in;
    logic [FP-1:0] c_in;
    logic          busy_out;
    logic [FP-1:0] answer_out;
    logic          ready_answer_out;
    logic          overflow_out;
    logic          underflow_out;
    logic          invalid_out;
    logic [2:0]    state_out;

    modport master (
        output req_in, acc_sel_in, a_in, b_in, c_in,
        input  busy_out, answer_out, ready_answer_out,
        input  overflow_out, underflow_out, invalid_out, state_out
    );

    modport slave (
        input  req_in, acc_sel_in, a_in, b_in, c_in,
        output busy_out, answer_out, ready_answer_out,
        output overflow_out, underflow_out, invalid_out, state_out
    );
endinterface

`default_nettype wire

// File: rtl/fpu_lzc.sv
// ============================================================================
// Module      : fpu_lzc
// Description : Parametrised leading-zero counter with all-zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_lzc #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  wire logic [WIDTH-1:0] i_data,
    output logic      [CW-1:0]    o_count,
    output logic                  o_all_zero
);

    // Higher bits are visited last, so the most significant one wins.
    always_comb begin
        o_count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_data[i]) begin
                o_count = CW'(WIDTH - 1 - i);
            end
        end
    end

    assign o_all_zero = ~|i_data;

endmodule

`default_nettype wire

// File: rtl/fpu_fma_param.sv
// ============================================================================
// Module      : fpu_fma_param
// Description : Multi-cycle parametrised fused multiply-add with accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_fma_param #(
    parameter int EXPBITS = 8,
    parameter int MANBITS = 23,
    parameter int FP      = 1 + EXPBITS + MANBITS
) (
    input wire logic       clk,
    input wire logic       rst,
    fpu_fma_param_if.slave bus
);
    import fpu_pkg::*;

    localparam int c_BIAS  = fp_bias(EXPBITS);
    localparam int c_PW    = 2 * (MANBITS + 1);
    localparam int c_SW    = c_PW + 1;
    localparam int c_XW    = EXPBITS + 2;
    localparam int c_DW    = EXPBITS + 3;
    localparam int c_LW    = $clog2(c_SW + 1);
    localparam int c_NW    = c_XW + c_LW + 1;
    localparam int c_SHMAX = 2 * MANBITS + 4;
    localparam int c_SHW   = (c_DW > $clog2(c_SHMAX + 1)) ? c_DW : $clog2(c_SHMAX + 1);
    localparam int c_EMAX  = (1 << EXPBITS) - 1;

    typedef struct packed {
        logic               sign;
        logic [EXPBITS-1:0] exp;
        logic [MANBITS-1:0] man;
    } float_t;

    localparam float_t c_NAN = '{sign: 1'b0, exp: '1, man: MANBITS'(1) << (MANBITS - 1)};

    fma_state_e r_state, w_next;

    float_t                  r_a, r_b, r_c, r_acc, r_answer;
    bool_e                   r_a_zero, r_b_zero, r_c_zero, r_pzero;
    logic [c_PW-1:0]         r_prod, r_pal, r_cal;
    logic signed [c_XW-1:0]  r_pexp, r_exp;
    logic                    r_psign, r_ssign;
    logic [c_SW-1:0]         r_sum;
    logic                    r_ovf, r_unf, r_inv;

    logic                    w_invalid;
    logic [c_PW-1:0]         w_prod, w_cplace, w_small_in, w_small_sh;
    logic signed [c_XW-1:0]  w_pexp, w_cexp;
    logic signed [c_DW-1:0]  w_diff;
    logic [c_SHW-1:0]        w_adiff;
    logic [c_LW-1:0]         w_lz;
    logic                    w_zero;
    logic [c_SW-1:0]         w_shifted;
    logic signed [c_NW-1:0]  w_nexp;
    float_t                  w_norm;
    logic                    w_ovf, w_unf;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:       if (bus.req_in) w_next = LOAD;
            LOAD:       w_next = w_invalid ? ERROR : MULTIPLY;
            MULTIPLY:   w_next = ALIGN;
            ALIGN:      w_next = ACCUMULATE;
            ACCUMULATE: w_next = NORMALIZE;
            NORMALIZE:  w_next = OUTPUT;
            ERROR:      w_next = OUTPUT;
            OUTPUT:     w_next = IDLE;
            default:    w_next = IDLE;
        endcase
    end

    // -------------------------------------------------------- combinational
    assign w_invalid = (fp_is_special(32'(r_a.exp), EXPBITS) == TRUE) ||
                       (fp_is_special(32'(r_b.exp), EXPBITS) == TRUE) ||
                       (fp_is_special(32'(r_c.exp), EXPBITS) == TRUE);

    assign w_prod   = c_PW'({1'b1, r_a.man}) * c_PW'({1'b1, r_b.man});
    assign w_pexp   = c_XW'(r_a.exp) + c_XW'(r_b.exp) - c_XW'(c_BIAS);

    // The addend is widened to the product's binary point (2*MANBITS fraction bits).
    assign w_cplace = c_PW'({1'b1, r_c.man}) << MANBITS;
    assign w_cexp   = c_XW'(r_c.exp);
    assign w_diff   = {r_pexp[c_XW-1], r_pexp} - c_DW'(r_c.exp);
    assign w_adiff  = c_SHW'(w_diff[c_DW-1] ? -w_diff : w_diff);
    assign w_small_in = w_diff[c_DW-1] ? r_prod : w_cplace;
    assign w_small_sh = (w_adiff >= c_SHW'(c_SHMAX)) ? '0 : (w_small_in >> w_adiff);

    fpu_lzc #(.WIDTH(c_SW)) u_lzc (
        .i_data     (r_sum),
        .o_count    (w_lz),
        .o_all_zero (w_zero)
    );

    assign w_shifted = r_sum << w_lz;
    assign w_nexp    = {{(c_NW - c_XW){r_exp[c_XW-1]}}, r_exp} + c_NW'(2) - c_NW'(w_lz);
    assign w_ovf     = (w_nexp >= $signed(c_NW'(c_EMAX)));
    assign w_unf     = (w_nexp <= $signed(c_NW'(0)));

    always_comb begin
        w_norm = '{sign: r_ssign, exp: w_nexp[EXPBITS-1:0], man: w_shifted[c_SW-2 -: MANBITS]};
        if (w_zero) begin
            w_norm = '0;
        end else if (w_ovf) begin
            w_norm = '{sign: r_ssign, exp: '1, man: '0};
        end else if (w_unf) begin
            w_norm = '{sign: r_ssign, exp: '0, man: '0};
        end
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_a_zero <= FALSE;
            r_b_zero <= FALSE;
            r_c_zero <= FALSE;
            r_pzero  <= FALSE;
            r_prod   <= '0;
            r_pexp   <= '0;
            r_psign  <= 1'b0;
            r_pal    <= '0;
            r_cal    <= '0;
            r_exp    <= '0;
            r_sum    <= '0;
            r_ssign  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_in) begin
                        r_a <= float_t'(bus.a_in);
                        r_b <= float_t'(bus.b_in);
                        r_c <= bus.acc_sel_in ? r_acc : float_t'(bus.c_in);
                    end
                end
                LOAD: begin
                    r_a_zero <= (r_a.exp == '0) ? TRUE : FALSE;
                    r_b_zero <= (r_b.exp == '0) ? TRUE : FALSE;
                    r_c_zero <= (r_c.exp == '0) ? TRUE : FALSE;
                end
                MULTIPLY: begin
                    r_pzero <= (r_a_zero == TRUE || r_b_zero == TRUE) ? TRUE : FALSE;
                    r_prod  <= (r_a_zero == TRUE || r_b_zero == TRUE) ? '0 : w_prod;
                    r_pexp  <= w_pexp;
                    r_psign <= r_a.sign ^ r_b.sign;
                end
                ALIGN: begin
                    if (r_pzero == TRUE) begin
                        r_pal <= '0;
                        r_cal <= (r_c_zero == TRUE) ? '0 : w_cplace;
                        r_exp <= w_cexp;
                    end else if (r_c_zero == TRUE) begin
                        r_pal <= r_prod;
                        r_cal <= '0;
                        r_exp <= r_pexp;
                    end else if (!w_diff[c_DW-1]) begin
                        r_pal <= r_prod;
                        r_cal <= w_small_sh;
                        r_exp <= r_pexp;
                    end else begin
                        r_pal <= w_small_sh;
                        r_cal <= w_cplace;
                        r_exp <= w_cexp;
                    end
                end
                ACCUMULATE: begin
                    if (r_psign == r_c.sign) begin
                        r_sum   <= c_SW'(r_pal) + c_SW'(r_cal);
                        r_ssign <= r_psign;
                    end else if (r_pal >= r_cal) begin
                        r_sum   <= c_SW'(r_pal - r_cal);
                        r_ssign <= r_psign;
                    end else begin
                        r_sum   <= c_SW'(r_cal - r_pal);
                        r_ssign <= r_c.sign;
                    end
                end
                default: ;
            endcase
        end
    end

    // Answer and flags are registered on entry to OUTPUT so they line up with the pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_answer <= '0;
            r_acc    <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_inv    <= 1'b0;
        end else begin
            case (r_state)
                NORMALIZE: begin
                    r_answer <= w_norm;
                    r_ovf    <= ~w_zero & w_ovf;
                    r_unf    <= ~w_zero & ~w_ovf & w_unf;
                    r_inv    <= 1'b0;
                end
                ERROR: begin
                    r_answer <= c_NAN;
                    r_ovf    <= 1'b0;
                    r_unf    <= 1'b0;
                    r_inv    <= 1'b1;
                end
                OUTPUT: r_acc <= r_answer;
                default: ;
            endcase
        end
    end

    assign bus.busy_out         = (r_state != IDLE);
    assign bus.ready_answer_out = (r_state == OUTPUT);
    assign bus.answer_out       = r_answer;
    assign bus.overflow_out     = r_ovf;
    assign bus.underflow_out    = r_unf;
    assign bus.invalid_out      = r_inv;
    assign bus.state_out        = r_state;

endmodule

`default_nettype wire

// File: tb/tb_fpu_fma_param.sv
// ============================================================================
// Module      : tb_fpu_fma_param
// Description : Self-checking bench for fpu_fma_param (single and half builds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_fma_param;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    fpu_fma_param_if #(.EXPBITS(8), .MANBITS(23)) sp_bus ();
    fpu_fma_param_if #(.EXPBITS(5), .MANBITS(10)) hp_bus ();

    fpu_fma_param #(.EXPBITS(8), .MANBITS(23)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (sp_bus)
    );

    fpu_fma_param #(.EXPBITS(5), .MANBITS(10)) u_dut_hp (
        .clk (clk),
        .rst (rst),
        .bus (hp_bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: exact integer product and addend on a 2^-46 grid, the smaller one
    // floored to the larger one's exponent, summed, then truncated to 24 bits.
    function automatic logic [34:0] ref_fma(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c);
        int ea, eb, ec, pexp, e, d, msb, bexp;
        longint p, cv, pal, cal, s, mag;
        logic sgn;
        logic [22:0] man;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ec = int'(c[30:23]);
        if (ea == 255 || eb == 255 || ec == 255) return {3'b100, 32'h7FC00000};
        p    = (ea == 0 || eb == 0) ? 64'sd0 :
               longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
        pexp = ea + eb - 127;
        cv   = (ec == 0) ? 64'sd0 : (longint'({1'b1, c[22:0]}) << 23);
        if (p == 0) begin
            pal = 0; cal = cv; e = ec;
        end else if (cv == 0) begin
            pal = p; cal = 0; e = pexp;
        end else begin
            d = pexp - ec;
            if (d >= 0) begin
                e = pexp; pal = p; cal = (d >= 50) ? 64'sd0 : (cv >>> d);
            end else begin
                e = ec; cal = cv; pal = (-d >= 50) ? 64'sd0 : (p >>> (-d));
            end
        end
        s = ((a[31] ^ b[31]) ? -pal : pal) + (c[31] ? -cal : cal);
        if (s == 0) return 35'h0;
        sgn = (s < 0);
        mag = sgn ? -s : s;
        msb = 0;
        for (int i = 0; i < 63; i++) if (mag[i]) msb = i;
        bexp = e + msb - 46;
        if (bexp >= 255) return {3'b010, sgn, 8'hFF, 23'h0};
        if (bexp <= 0)   return {3'b001, sgn, 31'h0};
        man = (msb >= 23) ? 23'(mag >> (msb - 23)) : 23'(mag << (23 - msb));
        return {3'b000, sgn, 8'(bexp), man};
    endfunction

    function automatic logic [31:0] rnd_fp();
        int r;
        logic [7:0] e;
        r = int'($urandom_range(0, 19));
        if (r == 0)      e = 8'h00;
        else if (r == 1) e = 8'hFF;
        else if (r <= 3) e = 8'($urandom_range(1, 254));
        else             e = 8'($urandom_range(107, 147));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          input logic acc, output logic [31:0] ans, output logic [2:0] flg,
                          output int lat, output logic [2:0] st2, output int busy_bad,
                          output logic idle_after);
        @(negedge clk);
        sp_bus.req_in = 1'b1; sp_bus.acc_sel_in = acc;
        sp_bus.a_in = a; sp_bus.b_in = b; sp_bus.c_in = c;
        @(posedge clk); #1;
        sp_bus.req_in = 1'b0;
        sp_bus.a_in = $urandom; sp_bus.b_in = $urandom; sp_bus.c_in = $urandom;
        sp_bus.acc_sel_in = 1'($urandom);
        lat = -1; busy_bad = 0; ans = '0; flg = '0; st2 = '0; idle_after = 1'b0;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            if (!sp_bus.busy_out) busy_bad++;
            if (k == 2) st2 = sp_bus.state_out;
            if (sp_bus.ready_answer_out) begin
                lat = k;
                ans = sp_bus.answer_out;
                flg = {sp_bus.invalid_out, sp_bus.overflow_out, sp_bus.underflow_out};
            end else begin
                @(posedge clk); #1;
            end
        end
        if (lat >= 0) begin
            @(posedge clk); #1;
            idle_after = !sp_bus.busy_out && !sp_bus.ready_answer_out && (sp_bus.state_out == 3'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] ans, a, b, c, p, acc_model;
        logic [2:0]  flg, st2;
        logic [34:0] exp_r;
        logic        idle, acc;
        int          lat, bb, pulses;

        sp_bus.req_in = 0; sp_bus.acc_sel_in = 0; sp_bus.a_in = 0; sp_bus.b_in = 0; sp_bus.c_in = 0;
        hp_bus.req_in = 0; hp_bus.acc_sel_in = 0; hp_bus.a_in = 0; hp_bus.b_in = 0; hp_bus.c_in = 0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        #1;
        chk("rst_busy",   64'(sp_bus.busy_out), 64'd0);
        chk("rst_ready",  64'(sp_bus.ready_answer_out), 64'd0);
        chk("rst_answer", 64'(sp_bus.answer_out), 64'd0);
        chk("rst_flags",  64'({sp_bus.invalid_out, sp_bus.overflow_out, sp_bus.underflow_out}), 64'd0);
        chk("rst_state",  64'(sp_bus.state_out), 64'd0);

        run_op(32'h3F800000, 32'h3F800000, 32'h0, 1'b0, ans, flg, lat, st2, bb, idle);
        chk("one_ans",   64'(ans), 64'h3F800000);
        chk("one_flags", 64'(flg), 64'd0);
        chk("one_lat",   64'(lat), 64'd6);
        chk("one_busy",  64'(bb), 64'd0);
        chk("one_st2",   64'(st2), 64'd2);
        chk("one_idle",  64'(idle), 64'd1);

        run_op(32'h40000000, 32'h40400000, 32'h3F800000, 1'b0, ans, flg, lat, st2, bb, idle);
        chk("seven_ans", 64'(ans), 64'h40E00000);
        chk("seven_flg", 64'(flg), 64'd0);
        run_op(32'h3FC00000, 32'h40000000, 32'hC2C80000, 1'b1, ans, flg, lat, st2, bb, idle);
        chk("acc_ans",   64'(ans), 64'h41200000);
        chk("acc_flg",   64'(flg), 64'd0);

        run_op(32'h7F000000, 32'h7F000000, 32'h0, 1'b0, ans, flg, lat, st2, bb, idle);
        chk("ovf_ans", 64'(ans), 64'h7F800000);
        chk("ovf_flg", 64'(flg), 64'b010);
        run_op(32'h00800000, 32'h00800000, 32'h0, 1'b0, ans, flg, lat, st2, bb, idle);
        chk("unf_ans", 64'(ans), 64'h00000000);
        chk("unf_flg", 64'(flg), 64'b001);

        // Request held high for the whole operation must produce a single answer.
        @(negedge clk);
        sp_bus.req_in = 1'b1; sp_bus.acc_sel_in = 1'b0;
        sp_bus.a_in = 32'h3F800000; sp_bus.b_in = 32'h3F800000; sp_bus.c_in = 32'hBF800000;
        pulses = 0; ans = 32'hFFFFFFFF; flg = 3'b111;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (sp_bus.ready_answer_out) begin
                pulses++;
                ans = sp_bus.answer_out;
                flg = {sp_bus.invalid_out, sp_bus.overflow_out, sp_bus.underflow_out};
                sp_bus.req_in = 1'b0;
            end
        end
        sp_bus.req_in = 1'b0;
        chk("held_pulses", 64'(pulses), 64'd1);
        chk("cancel_ans",  64'(ans), 64'h0);
        chk("cancel_flg",  64'(flg), 64'd0);

        run_op(32'h7FC00000, 32'h3F800000, 32'h0, 1'b0, ans, flg, lat, st2, bb, idle);
        chk("inv_ans",  64'(ans), 64'h7FC00000);
        chk("inv_flg",  64'(flg), 64'b100);
        chk("inv_lat",  64'(lat), 64'd3);
        chk("inv_st2",  64'(st2), 64'd7);
        chk("inv_idle", 64'(idle), 64'd1);

        // Asynchronous abort while in ALIGN.
        @(negedge clk);
        sp_bus.req_in = 1'b1; sp_bus.acc_sel_in = 1'b0;
        sp_bus.a_in = 32'h3FC00000; sp_bus.b_in = 32'h40000000; sp_bus.c_in = 32'h0;
        @(posedge clk); #1;
        sp_bus.req_in = 1'b0;
        for (int k = 0; k < 10 && sp_bus.state_out != 3'd3; k++) begin
            @(posedge clk); #1;
        end
        chk("abort_reached_align", 64'(sp_bus.state_out), 64'd3);
        #2; rst = 1'b0; #1;
        chk("abort_busy",   64'(sp_bus.busy_out), 64'd0);
        chk("abort_state",  64'(sp_bus.state_out), 64'd0);
        chk("abort_answer", 64'(sp_bus.answer_out), 64'd0);
        chk("abort_inv",    64'(sp_bus.invalid_out), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (sp_bus.ready_answer_out) pulses++;
        end
        chk("abort_no_pulse", 64'(pulses), 64'd0);
        run_op(32'h3F800000, 32'h3F800000, 32'h7F800000, 1'b1, ans, flg, lat, st2, bb, idle);
        chk("post_rst_ans", 64'(ans), 64'h3F800000);
        chk("post_rst_flg", 64'(flg), 64'd0);
        chk("post_rst_lat", 64'(lat), 64'd6);
        acc_model = ans;

        for (int n = 0; n < 40; n++) begin
            a   = rnd_fp();
            b   = rnd_fp();
            c   = rnd_fp();
            acc = ($urandom_range(0, 3) == 0);
            if (!acc && $urandom_range(0, 3) == 0) begin
                p = ref_fma(a, b, 32'h0)[31:0];
                c = {~p[31], p[30:1], p[0] ^ 1'($urandom)};
            end
            exp_r = ref_fma(a, b, acc ? acc_model : c);
            run_op(a, b, c, acc, ans, flg, lat, st2, bb, idle);
            chk($sformatf("rnd%0d_ans", n), 64'(ans), 64'(exp_r[31:0]));
            chk($sformatf("rnd%0d_flg", n), 64'(flg), 64'(exp_r[34:32]));
            acc_model = exp_r[31:0];
        end

        @(negedge clk);
        hp_bus.req_in = 1'b1; hp_bus.acc_sel_in = 1'b0;
        hp_bus.a_in = 16'h3C00; hp_bus.b_in = 16'h4000; hp_bus.c_in = 16'h3C00;
        @(posedge clk); #1;
        hp_bus.req_in = 1'b0;
        lat = -1; ans = '0;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            if (hp_bus.ready_answer_out) begin
                lat = k;
                ans = 32'(hp_bus.answer_out);
            end else begin
                @(posedge clk); #1;
            end
        end
        chk("half_ans", 64'(ans), 64'h4200);
        chk("half_lat", 64'(lat), 64'd6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
